oclib_clock_throttle_multi: RTL and testbench

Multi-channel successor to the single-output clock controller. It produces NumChannels gated clocks from one input clock. Each channel is gated by a per-channel throttle pattern ANDed with a thermal duty mask. The thermal throttle level is multi-step and ramps with hysteresis: it steps up fast and relaxes slowly, which limits di/dt. It sits between the board clock tree and user logic that needs power/thermal management.

---
 rtl/oclib_clock_throttle_multi_pkg.sv | 39 +++
 rtl/oclib_clock_throttle_multi_if.sv | 45 ++++
 rtl/oclib_clock_gate.sv | 44 ++++
 rtl/oclib_synchronizer.sv | 36 +++
 rtl/oclib_clock_throttle_multi.sv | 154 +++++++++++++++
 tb/tb_oclib_clock_throttle_multi.sv | 238 +++++++++++++++++++++++
 6 files changed

// File: rtl/oclib_clock_throttle_multi_pkg.sv
// ---------------------------------------------------------------------------
// oclib_clock_throttle_multi_pkg
//
// Purpose:
//   Shared types and helpers for the multi-channel clock throttle.
//   - oclib_throttle_level_e : thermal throttle level, 0 (full rate) to 3
//   - oclib_throttle_mask()  : thermal duty mask for a level and the low two
//                              bits of the shared pattern counter
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package oclib_clock_throttle_multi_pkg;

  // Width of the thermal level field on the external bus.
  localparam int ThrottleLevelW = 2;

  typedef enum logic [ThrottleLevelW-1:0] {
    ThrottleL0 = 2'd0,
    ThrottleL1 = 2'd1,
    ThrottleL2 = 2'd2,
    ThrottleL3 = 2'd3
  } oclib_throttle_level_e;

  // Duty mask within each 4-cycle group of the pattern counter:
  //   L0 passes 4/4, L1 drops the last slot, L2 passes even slots,
  //   L3 passes only the first slot.
  function automatic logic oclib_throttle_mask(input oclib_throttle_level_e level,
                                               input logic [1:0]            cnt2);
    logic pass;
    case (level)
      ThrottleL0: pass = 1'b1;
      ThrottleL1: pass = (cnt2 != 2'd3);
      ThrottleL2: pass = ~cnt2[0];
      default:    pass = (cnt2 == 2'd0);
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/oclib_clock_throttle_multi_if.sv
// ---------------------------------------------------------------------------
// oclib_clock_throttle_multi_if
//
// Purpose:
//   Bundles the control inputs and observation outputs of the clock throttle.
//
// Signals:
//   throttlePattern [NumChannels*PatternW] per-channel pattern, async
//   thermalLevel    [2]                    requested thermal level, async
//   channelEnable   [NumChannels]          synchronous per-channel enable
//   clockOut        [NumChannels]          gated clocks
//   clockEnable     [NumChannels]          registered gate enables
//   currentLevel    [2]                    applied thermal level
//   ramping         [1]                    applied level differs from target
//
// Modports:
//   master : drives the controls, observes the outputs
//   slave  : the throttle itself
// ---------------------------------------------------------------------------
interface oclib_clock_throttle_multi_if
  import oclib_clock_throttle_multi_pkg::*;
#(
  parameter int NumChannels = 2,
  parameter int PatternW    = 16
);

  logic [NumChannels*PatternW-1:0] throttlePattern;
  logic [ThrottleLevelW-1:0]       thermalLevel;
  logic [NumChannels-1:0]          channelEnable;
  logic [NumChannels-1:0]          clockOut;
  logic [NumChannels-1:0]          clockEnable;
  logic [ThrottleLevelW-1:0]       currentLevel;
  logic                            ramping;

  modport master (
    output throttlePattern, thermalLevel, channelEnable,
    input  clockOut, clockEnable, currentLevel, ramping
  );

  modport slave (
    input  throttlePattern, thermalLevel, channelEnable,
    output clockOut, clockEnable, currentLevel, ramping
  );

endinterface

// File: rtl/oclib_clock_gate.sv
// ---------------------------------------------------------------------------
// oclib_clock_gate
//
// Purpose:
//   Glitch-free clock gate. The enable is captured on the falling edge so it
//   is stable for the whole high phase, then ANDed with the clock (or fed to
//   a BUFGCTRL clock-enable on UltraScale+ devices).
//
// Ports:
//   clock    input  1  clock to gate
//   enable   input  1  gate enable, generated on the rising edge
//   clockOut output 1  gated clock
// ---------------------------------------------------------------------------
module oclib_clock_gate (
  input  logic clock,
  input  logic enable,
  output logic clockOut
);

  logic gate;

  // Falling-edge capture: the enable can only change while the clock is low.
  always_ff @(negedge clock) begin
    gate <= enable;
  end

`ifdef OC_LIBRARY_ULTRASCALE_PLUS
  // Only input 0 is ever selected; CE0 carries the negedge-registered gate.
  BUFGCTRL u_bufgctrl (
    .O       (clockOut),
    .CE0     (gate),
    .CE1     (1'b0),
    .I0      (clock),
    .I1      (1'b0),
    .IGNORE0 (1'b0),
    .IGNORE1 (1'b1),
    .S0      (1'b1),
    .S1      (1'b0)
  );
`else
  assign clockOut = clock & gate;
`endif

endmodule

// File: rtl/oclib_synchronizer.sv
// ---------------------------------------------------------------------------
// oclib_synchronizer
//
// Purpose:
//   Multi-flop synchronizer for slowly changing asynchronous inputs.
//   Each bit is synchronized independently, so multi-bit values must be
//   quasi-static (held long enough that a torn sample does not matter).
//
// Ports:
//   clock      input  1      destination clock
//   async_data input  Width  asynchronous value
//   sync_data  output Width  value after SyncCycles flops
// ---------------------------------------------------------------------------
module oclib_synchronizer #(
  parameter int Width      = 1,
  parameter int SyncCycles = 3
) (
  input  logic             clock,
  input  logic [Width-1:0] async_data,
  output logic [Width-1:0] sync_data
);

  logic [Width-1:0] stages [SyncCycles];

  // Plain shift chain without reset; the first stage may go metastable and
  // later stages give it time to resolve.
  always_ff @(posedge clock) begin
    stages[0] <= async_data;
    for (int i = 1; i < SyncCycles; i++) begin
      stages[i] <= stages[i-1];
    end
  end

  assign sync_data = stages[SyncCycles-1];

endmodule

// File: rtl/oclib_clock_throttle_multi.sv
// ---------------------------------------------------------------------------
// oclib_clock_throttle_multi
//
// Purpose:
//   Produces NumChannels gated clocks from one input clock. Each channel is
//   gated by its own repeating throttle pattern ANDed with a thermal duty
//   mask. The thermal level steps up quickly (one step per pattern period)
//   and relaxes slowly (a dwell of RampCycles per step) to limit di/dt.
//
// Ports:
//   clock  input  1  input clock; all logic on posedge except the gate flops
//   reset  input  1  synchronous, active-low reset
//   bus    slave modport of oclib_clock_throttle_multi_if:
//          throttlePattern, thermalLevel, channelEnable (in)
//          clockOut, clockEnable, currentLevel, ramping (out)
// ---------------------------------------------------------------------------
module oclib_clock_throttle_multi
  import oclib_clock_throttle_multi_pkg::*;
#(
  parameter int NumChannels = 2,
  parameter int PatternW    = 16,
  parameter int RampCycles  = 64,
  parameter int SyncCycles  = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  oclib_clock_throttle_multi_if.slave bus
);

  localparam int CntW   = $clog2(PatternW);
  localparam int DwellW = (RampCycles > 1) ? $clog2(RampCycles) : 1;

  localparam logic [CntW-1:0]   CntLast   = CntW'(PatternW - 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(RampCycles - 1);

  logic [NumChannels*PatternW-1:0] pattern_sync;
  logic [ThrottleLevelW-1:0]       level_sync;
  oclib_throttle_level_e           target;

  logic [CntW-1:0]        cnt;
  logic                   wrap;
  oclib_throttle_level_e  level_q;
  oclib_throttle_level_e  level_d;
  logic [DwellW-1:0]      dwell_q;
  logic [DwellW-1:0]      dwell_d;
  logic                   ramping_q;
  logic                   thermal_pass;
  logic [NumChannels-1:0] enable_d;
  logic [NumChannels-1:0] enable_q;
  logic [NumChannels-1:0] gated;

  // Asynchronous controls are brought into the clock domain before use.
  oclib_synchronizer #(
    .Width      (NumChannels * PatternW),
    .SyncCycles (SyncCycles)
  ) u_pattern_sync (
    .clock      (clock),
    .async_data (bus.throttlePattern),
    .sync_data  (pattern_sync)
  );

  oclib_synchronizer #(
    .Width      (ThrottleLevelW),
    .SyncCycles (SyncCycles)
  ) u_level_sync (
    .clock      (clock),
    .async_data (bus.thermalLevel),
    .sync_data  (level_sync)
  );

  assign target = oclib_throttle_level_e'(level_sync);

  // Shared pattern counter; PatternW is a power of two so it wraps naturally.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

  assign wrap = (cnt == CntLast);

  // Level ramp state register. ramping is registered against the next
  // level so it is low out of reset and tracks the applied level exactly.
  always_ff @(posedge clock) begin
    if (!reset) begin
      level_q   <= ThrottleL0;
      dwell_q   <= '0;
      ramping_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      dwell_q   <= dwell_d;
      ramping_q <= (level_d != target);
    end
  end

  // Level ramp next-state. Steps happen only at wrap, so a pattern period is
  // never split between two levels. Upward steps need no dwell; downward
  // steps wait for the dwell counter to saturate first.
  always_comb begin
    level_d = level_q;
    dwell_d = dwell_q;
    if (target > level_q) begin
      dwell_d = '0;
      if (wrap) begin
        level_d = oclib_throttle_level_e'(level_q + 2'd1);
      end
    end else if (target < level_q) begin
      if (dwell_q == DwellLast) begin
        if (wrap) begin
          level_d = oclib_throttle_level_e'(level_q - 2'd1);
          dwell_d = '0;
        end
      end else begin
        dwell_d = dwell_q + DwellW'(1);
      end
    end else begin
      dwell_d = '0;
    end
  end

  assign thermal_pass = oclib_throttle_mask(level_q, cnt[1:0]);

  // Per-channel enable: the pattern bit selected by the shared counter,
  // qualified by the channel enable and the thermal mask.
  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    logic [PatternW-1:0] chan_pattern;

    assign chan_pattern = pattern_sync[c*PatternW +: PatternW];
    assign enable_d[c]  = bus.channelEnable[c] & chan_pattern[cnt] & thermal_pass;

    oclib_clock_gate u_gate (
      .clock    (clock),
      .enable   (enable_q[c]),
      .clockOut (gated[c])
    );
  end

  // Registered gate enables, one cycle behind the counter value they use.
  always_ff @(posedge clock) begin
    if (!reset) begin
      enable_q <= '0;
    end else begin
      enable_q <= enable_d;
    end
  end

  assign bus.clockOut     = gated;
  assign bus.clockEnable  = enable_q;
  assign bus.currentLevel = level_q;
  assign bus.ramping      = ramping_q;

endmodule

// File: tb/tb_oclib_clock_throttle_multi.sv
// ---------------------------------------------------------------------------
// tb_oclib_clock_throttle_multi
//
// Purpose:
//   Self-checking bench for oclib_clock_throttle_multi: a vector table of
//   steady-state patterns/levels with hand-derived enable sequences, plus
//   hand-written sequences for reset, level ramps, enable drop and reset
//   during a ramp.
// ---------------------------------------------------------------------------
module tb_oclib_clock_throttle_multi;

  localparam int NumChannels = 2;
  localparam int PatternW    = 16;
  localparam int RampCycles  = 64;
  localparam int SyncCycles  = 3;

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [1:0]  en;
    logic [1:0]  lvl;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [1:0] sb_q [$];
  vec_t vecs [6];

  oclib_clock_throttle_multi_if #(
    .NumChannels (NumChannels),
    .PatternW    (PatternW)
  ) bus ();

  oclib_clock_throttle_multi #(
    .NumChannels (NumChannels),
    .PatternW    (PatternW),
    .RampCycles  (RampCycles),
    .SyncCycles  (SyncCycles)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Advance one rising edge; cyc counts edges since reset release, so the
  // counter value used at edge n is (n-1) mod 16.
  task automatic step();
    @(posedge clock);
    if (reset) cyc++;
    else cyc = 0;
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] p0, input logic [15:0] p1,
                               input logic [1:0] lvl, input logic [1:0] en);
    bus.throttlePattern = {p1, p0};
    bus.thermalLevel    = lvl;
    bus.channelEnable   = en;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input logic [1:0] e);
    sb_q.push_back(e);
  endtask

  task automatic popCheck(input string name);
    logic [1:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      checkOutput(name, 32'(bus.clockEnable), 32'(e));
    end
  endtask

  task automatic waitLevel(input logic [1:0] lvl, input int budget, output int at);
    int n;
    n  = 0;
    at = -1;
    while (bus.currentLevel !== lvl && n < budget) begin
      step();
      n++;
    end
    if (bus.currentLevel === lvl) at = cyc;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int at, c0, e, idx, a0, a1, a2, n;
    logic [15:0] exp_l3;

    vecs[0] = '{16'hFFFF, 16'h00FF, 2'b11, 2'd0, 16'hFFFF, 16'h00FF};
    vecs[1] = '{16'hFFFF, 16'hAAAA, 2'b11, 2'd1, 16'h7777, 16'h2222};
    vecs[2] = '{16'hFFFF, 16'h1234, 2'b11, 2'd2, 16'h5555, 16'h1014};
    vecs[3] = '{16'hF0F1, 16'hFFFF, 2'b11, 2'd3, 16'h1011, 16'h1111};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 2'b01, 2'd0, 16'hFFFF, 16'h0000};
    vecs[5] = '{16'h0000, 16'hFFFF, 2'b11, 2'd0, 16'h0000, 16'hFFFF};

    // Reset for 4 cycles, then release with full patterns at level 0.
    reset = 1'b0;
    applyStimulus(16'hFFFF, 16'hFFFF, 2'd0, 2'b11);
    repeat (2) step();
    checkOutput("rst_clockEnable", 32'(bus.clockEnable), 0);
    checkOutput("rst_level", 32'(bus.currentLevel), 0);
    checkOutput("rst_ramping", 32'(bus.ramping), 0);
    checkOutput("rst_clockOut", 32'(bus.clockOut), 0);
    repeat (2) step();
    reset = 1'b1;
    step();
    checkOutput("first_enable", 32'(bus.clockEnable), 3);
    step();
    checkOutput("clockOut_high", 32'(bus.clockOut), 3);
    #5;
    checkOutput("clockOut_low", 32'(bus.clockOut), 0);

    // Steady-state vectors: one full pattern period per vector.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].p0, vecs[v].p1, vecs[v].lvl, vecs[v].en);
      waitLevel(vecs[v].lvl, 600, at);
      checkOutput($sformatf("vec%0d_level", v), 32'(bus.currentLevel), 32'(vecs[v].lvl));
      repeat (6) step();
      checkOutput($sformatf("vec%0d_ramping", v), 32'(bus.ramping), 0);
      for (int k = 0; k < 16; k++) begin
        idx = cyc % 16;
        pushExpected({vecs[v].e1[idx], vecs[v].e0[idx]});
        step();
        popCheck($sformatf("vec%0d_enable_cnt%0d", v, idx));
      end
    end

    // Ramp up 0 -> 2: one step per wrap once the target is synchronized.
    applyStimulus(16'hFFFF, 16'hFFFF, 2'd2, 2'b11);
    c0 = cyc;
    e  = c0 + 4;
    while (e % 16 != 0) e++;
    waitLevel(2'd1, 100, at);
    checkOutput("up_l1_cycle", 32'(at), 32'(e));
    checkOutput("up_l1_ramping", 32'(bus.ramping), 1);
    waitLevel(2'd2, 100, at);
    checkOutput("up_l2_cycle", 32'(at), 32'(e + 16));
    checkOutput("up_l2_ramping", 32'(bus.ramping), 0);
    for (int k = 0; k < 4; k++) begin
      idx = cyc % 16;
      pushExpected((idx % 2 == 0) ? 2'b11 : 2'b00);
      step();
      popCheck($sformatf("half_rate_cnt%0d", idx));
    end

    // Level 3 with 0x5555, then drop channel 1 just before a pass slot.
    applyStimulus(16'h5555, 16'h5555, 2'd3, 2'b11);
    waitLevel(2'd3, 100, at);
    checkOutput("l3_level", 32'(bus.currentLevel), 3);
    repeat (6) step();
    n = 0;
    while (cyc % 16 != 1 && n < 32) begin step(); n++; end
    checkOutput("l3_both_pass", 32'(bus.clockEnable), 3);
    n = 0;
    while (cyc % 16 != 4 && n < 32) begin step(); n++; end
    applyStimulus(16'h5555, 16'h5555, 2'd3, 2'b01);
    step();
    checkOutput("drop_ch1_next", 32'(bus.clockEnable), 1);
    exp_l3 = 16'h1111;
    for (int k = 0; k < 12; k++) begin
      idx = cyc % 16;
      pushExpected({1'b0, exp_l3[idx]});
      step();
      popCheck($sformatf("drop_ch1_cnt%0d", idx));
    end

    // Relax 3 -> 0: each step needs a full dwell plus a wrap.
    applyStimulus(16'h5555, 16'h5555, 2'd0, 2'b11);
    c0 = cyc;
    waitLevel(2'd2, 300, a2);
    checkOutput("down_l2_level", 32'(bus.currentLevel), 2);
    checkOutput("down_l2_at_wrap", 32'(a2 % 16), 0);
    checkOutput("down_l2_dwell", 32'((a2 - c0) >= 67), 1);
    checkOutput("down_l2_ramping", 32'(bus.ramping), 1);
    waitLevel(2'd1, 300, a1);
    checkOutput("down_l1_level", 32'(bus.currentLevel), 1);
    checkOutput("down_l1_gap", 32'((a1 - a2) >= 64 && (a1 - a2) < 80), 1);
    checkOutput("down_l1_ramping", 32'(bus.ramping), 1);
    waitLevel(2'd0, 300, a0);
    checkOutput("down_l0_level", 32'(bus.currentLevel), 0);
    checkOutput("down_l0_gap", 32'((a0 - a1) >= 64 && (a0 - a1) < 80), 1);
    checkOutput("down_total", 32'((a0 - c0) >= 192), 1);
    checkOutput("down_l0_ramping", 32'(bus.ramping), 0);

    // Reset in the middle of a 2 -> 0 relax, then climb to 3 from scratch.
    applyStimulus(16'hFFFF, 16'hFFFF, 2'd2, 2'b11);
    waitLevel(2'd2, 100, at);
    checkOutput("pre_l2_level", 32'(bus.currentLevel), 2);
    applyStimulus(16'hFFFF, 16'hFFFF, 2'd0, 2'b11);
    repeat (30) step();
    checkOutput("mid_ramp_level", 32'(bus.currentLevel), 2);
    checkOutput("mid_ramp_ramping", 32'(bus.ramping), 1);
    reset = 1'b0;
    applyStimulus(16'hFFFF, 16'hFFFF, 2'd3, 2'b11);
    repeat (2) step();
    checkOutput("rst2_level", 32'(bus.currentLevel), 0);
    checkOutput("rst2_clockEnable", 32'(bus.clockEnable), 0);
    checkOutput("rst2_ramping", 32'(bus.ramping), 0);
    checkOutput("rst2_clockOut", 32'(bus.clockOut), 0);
    step();
    reset = 1'b1;
    waitLevel(2'd1, 100, at);
    checkOutput("climb_l1_cycle", 32'(at), 16);
    waitLevel(2'd2, 100, at);
    checkOutput("climb_l2_cycle", 32'(at), 32);
    waitLevel(2'd3, 100, at);
    checkOutput("climb_l3_cycle", 32'(at), 48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
